instruction_fetch: RTL
======================

# instruction_fetch

Instruction fetch stage of the pipelined CPU, directly upstream of the operand-preparation (register read) stage. It owns the PC, issues word fetches to instruction memory over a request/acknowledge handshake, and buffers returned instructions with their PCs in a small FIFO. The FIFO feeds decode through a valid/ready handshake. A taken-branch redirect from the execute stage flushes the buffer and restarts fetch at the target.

## Interface
- QUEUE_DEPTH, 2, FIFO entries; a power of 2 in the range 2..8.
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

- clock  in  1  main clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- memReq  out  1  fetch request; held high until memAck.
- memAddr  out  32  word address of the request; stable while memReq is high.
- memAck  in  1  memData is valid; completes the single outstanding request; ignored when memReq=0.
- memData  in  32  instruction word.
- redirect  in  1  taken branch; one-cycle pulse.
- redirectTarget  in  32  new PC; bits [1:0] are ignored and treated as 0.
- instValid  out  1  head FIFO entry is valid.
- instruction  out  32  head instruction.
- instPC  out  32  PC of the head instruction.
- instReady  in  1  decode accepts the head entry when instValid && instReady.

## Operation
- **State:**
  - fetchPC (32 bits)
  - pendingTarget (32 bits)
  - FIFO of {PC, instruction}
  - count (0..QUEUE_DEPTH)
  - FSM with states FETCH, STALL, DRAIN
- **FETCH:**
  - memReq=1, memAddr=fetchPC.
  - On memAck: push {fetchPC, memData} and set fetchPC+=4 (wraps modulo 2^32).
  - Next state is FETCH if the post-push count (including a same-cycle pop) is < QUEUE_DEPTH; otherwise STALL.
- **STALL:**
  - memReq=0.
  - Go to FETCH in the cycle a pop occurs.
- **DRAIN:**
  - memReq=1 with the old memAddr held.
  - On memAck: discard the data, set fetchPC=pendingTarget, go to FETCH.
- **Redirect (highest priority):**
  - Clears count; the accept handshake in the same cycle is ignored.
  - FETCH without a same-cycle memAck: pendingTarget=target, go to DRAIN.
  - FETCH with a same-cycle memAck: discard the data, fetchPC=target, stay in FETCH.
  - STALL: fetchPC=target, go to FETCH.
  - DRAIN: pendingTarget is overwritten with the newest target; stay in DRAIN.
- **Simultaneous push and pop:** count is unchanged; this is legal even when count==QUEUE_DEPTH-1.
- **Pointer wrap:** FIFO pointers wrap modulo QUEUE_DEPTH.
- **Overflow guard:** a push never occurs when full, because FETCH is left before the FIFO fills.
- **Head outputs:** instruction and instPC come combinationally from the head entry. instValid = (count != 0).

## Timing
- **Reset values (while reset is high and on the first cycle after release):**
  - State: fetchPC=RESET_PC, count=0, state=FETCH.
  - Outputs while reset is high: memReq=0, instValid=0, instruction=0, instPC=0.
- **After reset release:** memReq=1 with memAddr=RESET_PC in the first cycle.
- **Reset mid-transaction:** the outstanding request is abandoned. Instruction memory is reset by the same reset, so no stale memAck arrives.
- **Fetch latency:** memAck in cycle n gives instValid=1 in cycle n+1.
- **Throughput:** one instruction per cycle with zero-wait memory and instReady held high.
- **Redirect in cycle n:**
  - instValid=0 in cycle n+1.
  - memAddr=target in cycle n+1, unless in DRAIN.
  - From DRAIN: memAddr=target in the cycle after the stale memAck.

## Configuration
- FETCH_PERF_COUNT_EN defined:
  - Adds output port fetchStarve (out, 32 bits).
  - It increments every non-reset cycle in which instValid=0 and saturates at 32'hFFFF_FFFF.
  - reset clears it to 0.
- FETCH_PERF_COUNT_EN undefined: the port and the counter logic are absent.

## Test plan
- **Zero-wait memory, instReady=1:** after reset, instPC sequence 0, 4, 8, 12 is delivered on consecutive cycles, and instruction equals memData for each address.
- **Backpressure:** instReady=0, QUEUE_DEPTH=2 → after two acks memReq=0 (STALL). Raise instReady for one cycle → memReq=1 on the next cycle, and instPC order is preserved.
- **Redirect without a pending ack:** memory latency 3 cycles, redirect to 32'h100 one cycle after a request to 32'h8 → the ack for 32'h8 is discarded, next memAddr=32'h100, and the next delivered instPC=32'h100.
- **Redirect coincident with memAck and instReady:** target 32'h0000_0042 → the acked data is dropped, instValid=0 next cycle, memAddr=32'h40.
- **Wrap:** RESET_PC=32'hFFFF_FFFC → instPC sequence 32'hFFFF_FFFC, then 32'h0000_0000.
- **Reset mid-request, and counter (with FETCH_PERF_COUNT_EN):**
  - reset asserted during memReq → memReq=0 next cycle, count=0, then a restart at RESET_PC.
  - fetchStarve equals the number of cycles instValid=0 after reset release, e.g. 1 with zero-wait memory.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the PC, fetches words from instruction memory over a
// req/ack handshake and buffers {PC, instruction} pairs in a small FIFO that
// feeds decode. A taken-branch redirect flushes the buffer and restarts fetch.
// Optional build macro: FETCH_PERF_COUNT_EN adds the fetchStarve counter port.
module instruction_fetch #(
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        memReq,
  output logic [31:0] memAddr,
  input  logic        memAck,
  input  logic [31:0] memData,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        instValid,
  output logic [31:0] instruction,
  output logic [31:0] instPC,
  input  logic        instReady
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [31:0] fetchStarve
`endif
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetchPC_q, fetchPC_d;
  logic [31:0]      pendingTarget_q, pendingTarget_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [31:0]      fifoPC_q   [QUEUE_DEPTH];
  logic [31:0]      fifoInst_q [QUEUE_DEPTH];

  logic [31:0]      targetAligned;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] postCount;

  // Redirect kills both the decode handshake and any push; the low target bits are dropped.
  always_comb begin
    targetAligned = redirectTarget & ~32'h3;
    push          = (state_q == FETCH) && memAck && !redirect;
    pop           = (count_q != '0) && instReady && !redirect;
    postCount     = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Next-state logic for the fetch FSM, PC, pending target and FIFO bookkeeping.
  always_comb begin
    state_d         = state_q;
    fetchPC_d       = fetchPC_q;
    pendingTarget_d = pendingTarget_q;
    count_d         = postCount;
    rdPtr_d         = rdPtr_q + PTR_W'(pop);
    wrPtr_d         = wrPtr_q + PTR_W'(push);

    if (redirect) begin
      count_d = '0;
      rdPtr_d = '0;
      wrPtr_d = '0;
    end

    case (state_q)
      FETCH: begin
        if (redirect) begin
          if (memAck) begin
            fetchPC_d = targetAligned;
          end else begin
            pendingTarget_d = targetAligned;
            state_d         = DRAIN;
          end
        end else if (memAck) begin
          fetchPC_d = fetchPC_q + 32'd4;
          state_d   = (postCount < DEPTH_C) ? FETCH : STALL;
        end
      end
      STALL: begin
        if (redirect) begin
          fetchPC_d = targetAligned;
          state_d   = FETCH;
        end else if (pop) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // A redirect landing on the stale ack itself uses the newest target so
        // the FSM never waits for an ack that will not come.
        if (memAck) begin
          fetchPC_d = redirect ? targetAligned : pendingTarget_q;
          state_d   = FETCH;
        end else if (redirect) begin
          pendingTarget_d = targetAligned;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= FETCH;
      fetchPC_q       <= RESET_PC;
      pendingTarget_q <= RESET_PC;
      count_q         <= '0;
      rdPtr_q         <= '0;
      wrPtr_q         <= '0;
    end else begin
      state_q         <= state_d;
      fetchPC_q       <= fetchPC_d;
      pendingTarget_q <= pendingTarget_d;
      count_q         <= count_d;
      rdPtr_q         <= rdPtr_d;
      wrPtr_q         <= wrPtr_d;
    end
  end

  // FIFO storage; contents need no reset because count gates validity.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      fifoPC_q[wrPtr_q]   <= fetchPC_q;
      fifoInst_q[wrPtr_q] <= memData;
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    memReq      = !reset && (state_q != STALL);
    memAddr     = fetchPC_q;
    instValid   = !reset && (count_q != '0);
    instruction = reset ? 32'h0 : fifoInst_q[rdPtr_q];
    instPC      = reset ? 32'h0 : fifoPC_q[rdPtr_q];
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] starve_q;

  // Saturating count of cycles in which decode had nothing to take.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= 32'h0;
    end else if (!instValid && (starve_q != 32'hFFFF_FFFF)) begin
      starve_q <= starve_q + 32'd1;
    end
  end

  assign fetchStarve = starve_q;
`endif

endmodule
